// File: rtl/rhythm_game_ctrl.sv
// Rhythm game controller: debounced button, falling square, hit-zone judging, BCD score.
// Define RHYTHM_LIVES_EN to enable lives tracking and the OVER state.
module rhythm_game_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int Y_MAX    = 779,
    parameter int ZONE_TOP = 400,
    parameter int ZONE_BOT = 475,
    parameter int BTN_DB   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    output logic [9:0]  square_y,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [1:0]  state,
    output logic        hit_pulse,
    output logic        miss_pulse
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FALL   = 2'd1,
        LOCKED = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int CW = $clog2(BTN_DB + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(BTN_DB - 1);
    localparam logic [9:0]    Y_LAST    = 10'(Y_MAX);
    localparam logic [9:0]    Y_ZBOT    = 10'(ZONE_BOT);
    // A late exit only exists when the zone ends before the wrap line.
    localparam bit            LATE_OK   = (ZONE_BOT < Y_MAX);

    state_t          state_q;
    state_t          state_d;
    logic            sync1;
    logic            sync2;
    logic            db_level;
    logic            db_prev;
    logic [CW-1:0]   db_cnt;
    logic            press;
    logic [TW-1:0]   tick_cnt;
    logic            running;
    logic            step;
    logic            wrap;
    logic            in_zone;
    logic            late_exit;
    logic            last_life;
    logic            hit;
    logic            miss;
    logic [15:0]     score_inc;
    logic            bcd_carry;
    logic [3:0]      bcd_digit;

    assign press     = db_level & ~db_prev;
    assign running   = (state_q == FALL) || (state_q == LOCKED);
    assign step      = running && (tick_cnt == TICK_LAST);
    assign wrap      = step && (square_y == Y_LAST);
    assign in_zone   = (int'(square_y) >= ZONE_TOP) && (int'(square_y) <= ZONE_BOT);
    assign late_exit = LATE_OK && step && (square_y == Y_ZBOT);
    assign state     = state_q;

`ifdef RHYTHM_LIVES_EN
    assign last_life = (lives == 2'd1);
`else
    assign last_life = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (press) state_d = FALL;
            end
            FALL: begin
                if (hit) state_d = LOCKED;
                else if (miss) state_d = last_life ? OVER : LOCKED;
            end
            LOCKED: begin
                if (wrap) state_d = FALL;
            end
            OVER: begin
`ifdef RHYTHM_LIVES_EN
                if (press) state_d = IDLE;
`else
                state_d = OVER;
`endif
            end
        endcase
    end

    // Judgement uses the pre-step square_y, so a press on the exit step still counts as a hit.
    always_comb begin
        hit  = 1'b0;
        miss = 1'b0;
        if (state_q == FALL) begin
            if (press) begin
                hit  = in_zone;
                miss = !in_zone;
            end else begin
                miss = late_exit;
            end
        end
    end

    always_comb begin
        score_inc = score;
        bcd_carry = 1'b1;
        bcd_digit = 4'd0;
        for (int i = 0; i < 4; i++) begin
            bcd_digit = score[4*i +: 4];
            if (bcd_carry) begin
                if (bcd_digit == 4'd9) begin
                    bcd_digit = 4'd0;
                end else begin
                    bcd_digit = bcd_digit + 4'd1;
                    bcd_carry = 1'b0;
                end
            end
            score_inc[4*i +: 4] = bcd_digit;
        end
        if (score == 16'h9999) score_inc = score;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db_level   <= 1'b0;
            db_prev    <= 1'b0;
            db_cnt     <= '0;
            tick_cnt   <= '0;
            square_y   <= '0;
            score      <= '0;
            lives      <= 2'd3;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            sync1   <= button;
            sync2   <= sync1;
            db_prev <= db_level;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            hit_pulse  <= hit;
            miss_pulse <= miss;

            if ((state_q == IDLE) && press) begin
                tick_cnt <= '0;
                square_y <= '0;
                score    <= '0;
                lives    <= 2'd3;
            end else begin
                if (running) begin
                    if (step) begin
                        tick_cnt <= '0;
                        square_y <= wrap ? 10'd0 : square_y + 10'd1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                if (hit) score <= score_inc;
`ifdef RHYTHM_LIVES_EN
                if (miss) lives <= lives - 2'd1;
`endif
            end
        end
    end
endmodule
